// File: rtl/serial_subtractor_controller_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN (signed overflow flag).
package serial_sub_pkg;

    // Default operand/result width in bits
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_controller_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// Overflow_Out exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_controller_if
    import serial_sub_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  Start_In;
    logic [DATA_WIDTH-1:0] Data_A_In;
    logic [DATA_WIDTH-1:0] Data_B_In;
    logic                  Borrow_In;
    logic                  Busy_Out;
    logic                  Done_Out;
    logic [DATA_WIDTH-1:0] Difference_Out;
    logic                  Borrow_Out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic                  Overflow_Out;
`endif

    // Requesting side: issues operands, observes results
    modport master (
        output Start_In,
        output Data_A_In,
        output Data_B_In,
        output Borrow_In,
`ifdef SERIAL_SUB_OVERFLOW_EN
        input  Overflow_Out,
`endif
        input  Busy_Out,
        input  Done_Out,
        input  Difference_Out,
        input  Borrow_Out
    );

    // Subtractor side: consumes operands, produces results
    modport slave (
        input  Start_In,
        input  Data_A_In,
        input  Data_B_In,
        input  Borrow_In,
`ifdef SERIAL_SUB_OVERFLOW_EN
        output Overflow_Out,
`endif
        output Busy_Out,
        output Done_Out,
        output Difference_Out,
        output Borrow_Out
    );

endinterface

// File: rtl/serial_subtractor_controller_full_subtractor.sv
// One-bit full subtractor cell: Sum_Out = A - B - Bin (mod 2), Borrow_Out
// set when A < B + Bin.
module Full_Subtractor (
    input  logic Data_A_In,
    input  logic Data_B_In,
    input  logic Borrow_In,
    output logic Borrow_Out,
    output logic Sum_Out
);

    // Difference bit and outgoing borrow of a single bit position
    always_comb begin
        Sum_Out    = Data_A_In ^ Data_B_In ^ Borrow_In;
        Borrow_Out = (~Data_A_In & Data_B_In) | (~(Data_A_In ^ Data_B_In) & Borrow_In);
    end

endmodule

// File: rtl/serial_subtractor_controller.sv
// Bit-serial subtractor: runs one Full_Subtractor cell over DATA_WIDTH
// cycles, LSB first, computing A - B - Borrow_In with a start/done handshake.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the signed overflow flag.
module serial_subtractor_controller
    import serial_sub_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    serial_subtractor_controller_if.slave bus
);

    localparam int             CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    state_t                state_r;
    state_t                state_nx_s;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] b_r;
    // Holds the DATA_WIDTH-1 difference bits already produced; the last bit
    // comes straight from the cell when the result is loaded.
    logic [DATA_WIDTH-2:0] res_r;
    logic [DATA_WIDTH-1:0] res_nx_s;
    logic                  borrow_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  busy_r;
    logic                  done_r;
    logic [DATA_WIDTH-1:0] diff_r;
    logic                  borrow_out_r;
    logic                  sum_s;
    logic                  cell_borrow_s;
    logic                  last_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic                  a_msb_r;
    logic                  b_msb_r;
    logic                  ovf_r;
`endif

    Full_Subtractor u_cell (
        .Data_A_In  (a_r[0]),
        .Data_B_In  (b_r[0]),
        .Borrow_In  (borrow_r),
        .Borrow_Out (cell_borrow_s),
        .Sum_Out    (sum_s)
    );

    // Result register contents after this cycle's bit is shifted in
    always_comb begin
        res_nx_s = {sum_s, res_r};
        last_s   = (cnt_r == LAST_CNT);
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.Start_In) begin
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Status outputs registered from the next state so they line up with it
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != IDLE);
            done_r <= (state_nx_s == DONE);
        end
    end

    // Operand capture, serial shifting and result load
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_r          <= '0;
            b_r          <= '0;
            res_r        <= '0;
            borrow_r     <= 1'b0;
            cnt_r        <= '0;
            diff_r       <= '0;
            borrow_out_r <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_r      <= 1'b0;
            b_msb_r      <= 1'b0;
            ovf_r        <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.Start_In) begin
                        a_r      <= bus.Data_A_In;
                        b_r      <= bus.Data_B_In;
                        borrow_r <= bus.Borrow_In;
                        res_r    <= '0;
                        cnt_r    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        a_msb_r  <= bus.Data_A_In[DATA_WIDTH-1];
                        b_msb_r  <= bus.Data_B_In[DATA_WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_r      <= {1'b0, a_r[DATA_WIDTH-1:1]};
                    b_r      <= {1'b0, b_r[DATA_WIDTH-1:1]};
                    res_r    <= res_nx_s[DATA_WIDTH-1:1];
                    borrow_r <= cell_borrow_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        diff_r       <= res_nx_s;
                        borrow_out_r <= cell_borrow_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        ovf_r        <= (a_msb_r != b_msb_r) & (sum_s != a_msb_r);
`endif
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.Busy_Out       = busy_r;
    assign bus.Done_Out       = done_r;
    assign bus.Difference_Out = diff_r;
    assign bus.Borrow_Out     = borrow_out_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign bus.Overflow_Out   = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor_controller.sv
// Self-checking bench for serial_subtractor_controller (DATA_WIDTH = 8).
// Directed cases plus 1000 random operations against an arithmetic model.
// Overflow checks are active when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_controller;
    import serial_sub_pkg::*;

    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_controller_if #(.DATA_WIDTH(DW)) bus ();

    serial_subtractor_controller #(.DATA_WIDTH(DW)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction
    function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [31:0] d;
        d = 32'(a) - 32'(b) - 32'(bin);
        return d[7:0];
    endfunction

    function automatic logic ref_borrow(input logic [7:0] a, input logic [7:0] b, input logic bin);
        return (int'(a) < int'(b) + int'(bin));
    endfunction

    function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b, input logic bin);
        logic [7:0] d;
        d = ref_diff(a, b, bin);
        return (a[7] != b[7]) && (d[7] != a[7]);
    endfunction

    function automatic logic get_ovf();
`ifdef SERIAL_SUB_OVERFLOW_EN
        return bus.Overflow_Out;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one start pulse; return latency (cycles after start edge) and busy count
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output int lat, output int bcnt);
        @(negedge clk);
        bus.Start_In  = 1'b1;
        bus.Data_A_In = a;
        bus.Data_B_In = b;
        bus.Borrow_In = bin;
        @(negedge clk);
        bus.Start_In  = 1'b0;
        bus.Data_A_In = ~a;
        bus.Data_B_In = ~b;
        bus.Borrow_In = ~bin;
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.Busy_Out === 1'b1) bcnt++;
            if (bus.Done_Out === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic bin, input bit chk_busy);
        int lat;
        int bcnt;
        logic [7:0] exp_d;
        exp_d = ref_diff(a, b, bin);
        run_op(a, b, bin, lat, bcnt);
        chk({tag, "_latency"}, 32'(lat), 32'd9);
        chk({tag, "_diff"}, 32'(bus.Difference_Out), 32'(exp_d));
        chk({tag, "_borrow"}, 32'(bus.Borrow_Out), 32'(ref_borrow(a, b, bin)));
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk({tag, "_ovf"}, 32'(get_ovf()), 32'(ref_ovf(a, b, bin)));
`endif
        if (chk_busy) chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd9);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(bus.Done_Out), 32'd0);
        chk({tag, "_diff_held"}, 32'(bus.Difference_Out), 32'(exp_d));
    endtask

    initial begin
        int         t[2];
        logic [7:0] dres[2];
        logic       bres[2];
        int         dcnt;
        int         first_n;
        logic [7:0] first_d;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;

        bus.Start_In  = 1'b0;
        bus.Data_A_In = 8'h00;
        bus.Data_B_In = 8'h00;
        bus.Borrow_In = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.Busy_Out), 32'd0);
        chk("rst_done", 32'(bus.Done_Out), 32'd0);
        chk("rst_diff", 32'(bus.Difference_Out), 32'd0);
        chk("rst_borrow", 32'(bus.Borrow_Out), 32'd0);
        chk("rst_ovf", 32'(get_ovf()), 32'd0);
        rst_n = 1'b1;

        // Directed arithmetic
        check_op("op_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b1);
        check_op("op_00_01_b1", 8'h00, 8'h01, 1'b1, 1'b1);
        check_op("op_80_01", 8'h80, 8'h01, 1'b0, 1'b0);
        check_op("op_10_01", 8'h10, 8'h01, 1'b0, 1'b0);
        check_op("op_ff_ff_b1", 8'hFF, 8'hFF, 1'b1, 1'b0);

        // Start during SHIFT cycle 3 is ignored
        @(negedge clk);
        bus.Start_In = 1'b1; bus.Data_A_In = 8'h77; bus.Data_B_In = 8'h12; bus.Borrow_In = 1'b0;
        @(negedge clk);
        bus.Start_In = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.Start_In = 1'b1; bus.Data_A_In = 8'h01; bus.Data_B_In = 8'h90; bus.Borrow_In = 1'b1;
        @(negedge clk);
        bus.Start_In = 1'b0;
        dcnt = 0; first_n = -1; first_d = 8'h00;
        for (int n = 1; n <= 21; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.Done_Out === 1'b1) begin
                if (dcnt == 0) begin
                    first_n = n;
                    first_d = bus.Difference_Out;
                end
                dcnt++;
            end
        end
        chk("ign_done_count", 32'(dcnt), 32'd1);
        chk("ign_done_time", 32'(first_n), 32'd6);
        chk("ign_diff", 32'(first_d), 32'(ref_diff(8'h77, 8'h12, 1'b0)));

        // Start held high: two back-to-back operations
        @(negedge clk);
        bus.Start_In = 1'b1; bus.Data_A_In = 8'h5A; bus.Data_B_In = 8'h3C; bus.Borrow_In = 1'b0;
        @(negedge clk);
        bus.Data_A_In = 8'hC3; bus.Data_B_In = 8'h47; bus.Borrow_In = 1'b1;
        dcnt = 0;
        t[0] = -1; t[1] = -1;
        dres[0] = 8'h00; dres[1] = 8'h00; bres[0] = 1'b0; bres[1] = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.Done_Out === 1'b1) begin
                t[dcnt]    = n;
                dres[dcnt] = bus.Difference_Out;
                bres[dcnt] = bus.Borrow_Out;
                dcnt++;
                if (dcnt == 2) begin
                    bus.Start_In = 1'b0;
                    break;
                end
            end
        end
        bus.Start_In = 1'b0;
        chk("held_done_count", 32'(dcnt), 32'd2);
        chk("held_first_time", 32'(t[0]), 32'd9);
        chk("held_spacing", 32'(t[1] - t[0]), 32'd10);
        chk("held_diff0", 32'(dres[0]), 32'(ref_diff(8'h5A, 8'h3C, 1'b0)));
        chk("held_borrow0", 32'(bres[0]), 32'(ref_borrow(8'h5A, 8'h3C, 1'b0)));
        chk("held_diff1", 32'(dres[1]), 32'(ref_diff(8'hC3, 8'h47, 1'b1)));
        chk("held_borrow1", 32'(bres[1]), 32'(ref_borrow(8'hC3, 8'h47, 1'b1)));
        repeat (3) @(negedge clk);

        // Reset during SHIFT cycle 4 aborts the operation
        @(negedge clk);
        bus.Start_In = 1'b1; bus.Data_A_In = 8'h10; bus.Data_B_In = 8'h20; bus.Borrow_In = 1'b0;
        @(negedge clk);
        bus.Start_In = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.Busy_Out), 32'd0);
        chk("abort_done", 32'(bus.Done_Out), 32'd0);
        chk("abort_diff", 32'(bus.Difference_Out), 32'd0);
        chk("abort_borrow", 32'(bus.Borrow_Out), 32'd0);
        chk("abort_ovf", 32'(get_ovf()), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (bus.Done_Out === 1'b1) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        check_op("post_abort", 8'hA5, 8'h5B, 1'b1, 1'b1);

        // Random operations against the model
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom_range(255, 0));
            rb   = 8'($urandom_range(255, 0));
            rbin = 1'($urandom_range(1, 0));
            check_op("rand", ra, rb, rbin, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
